// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver with a fractional oversampling tick, line-idle and end-of-packet detection.
// Define UART_RX_FRAME_ERR_EN to add the rxd_frame_err strobe (framing errors and false starts).
module uart_rx_framer #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD          = 12_000_000,
  parameter int unsigned OVERSAMPLING  = 8,
  parameter int unsigned ACC_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       rxd_data_ready,
  output logic [7:0] rxd_data,
  output logic       rxd_idle,
`ifdef UART_RX_FRAME_ERR_EN
  output logic       rxd_frame_err,
`endif
  output logic       rxd_endofpacket
);

  localparam logic [63:0] INC_WIDE =
    (((64'(BAUD) * 64'(OVERSAMPLING)) << ACC_WIDTH) + 64'(CLK_FREQUENCY / 2)) / 64'(CLK_FREQUENCY);
  localparam logic [ACC_WIDTH-1:0] INC = INC_WIDE[ACC_WIDTH-1:0];

  localparam int CNT_W = $clog2(OVERSAMPLING);
  localparam int GAP_W = $clog2(2 * OVERSAMPLING + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLING - 1);
  localparam logic [GAP_W-1:0] GAP_SAT   = GAP_W'(2 * OVERSAMPLING);

  typedef enum logic [3:0] {
    IDLE, START, BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7, STOP, BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH:0]   accSum;
  logic                 tick;
  logic                 sync1_q, sync2_q, sample_q, filt_q, filt_d;
  logic [CNT_W-1:0]     sampleCnt_q, sampleCnt_d;
  logic [7:0]           shift_q, shift_d, data_q, data_d;
  logic                 ready_q, ready_d, seen_q, seen_d, eop_q, eop_d;
  logic [GAP_W-1:0]     gapCnt_q, gapCnt_d;
  logic                 halfDone, bitDone;
`ifdef UART_RX_FRAME_ERR_EN
  logic                 frameErr_q, frameErr_d;
`endif

  // Phase accumulator: its carry-out is the oversampling tick.
  assign accSum = {1'b0, acc_q} + {1'b0, INC};
  assign tick   = accSum[ACC_WIDTH];

  // The filtered bit only follows the line once two consecutive tick samples agree.
  always_comb begin
    filt_d = filt_q;
    if (tick && (sync2_q == sample_q)) filt_d = sync2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      sample_q <= 1'b1;
      filt_q   <= 1'b1;
    end else begin
      acc_q   <= accSum[ACC_WIDTH-1:0];
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      if (tick) begin
        sample_q <= sync2_q;
        filt_q   <= filt_d;
      end
    end
  end

  assign halfDone = tick && (sampleCnt_q == HALF_LAST);
  assign bitDone  = tick && (sampleCnt_q == FULL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (tick && !filt_d) state_d = START;
      START: if (halfDone) state_d = filt_d ? IDLE : BIT0;
      BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6:
             if (bitDone) state_d = state_t'(state_q + 4'd1);
      BIT7:  if (bitDone) state_d = STOP;
      STOP:  if (bitDone) state_d = filt_d ? IDLE : BREAK;
      BREAK: if (filt_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sampleCnt_d = sampleCnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    ready_d     = 1'b0;
    seen_d      = seen_q;
`ifdef UART_RX_FRAME_ERR_EN
    frameErr_d  = 1'b0;
`endif
    case (state_q)
      START: begin
        if (tick) sampleCnt_d = halfDone ? '0 : sampleCnt_q + 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
        if (halfDone && filt_d) frameErr_d = 1'b1;
`endif
      end
      BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: begin
        if (tick) sampleCnt_d = bitDone ? '0 : sampleCnt_q + 1'b1;
        if (bitDone) shift_d = {filt_d, shift_q[7:1]};
      end
      STOP: begin
        if (tick) sampleCnt_d = bitDone ? '0 : sampleCnt_q + 1'b1;
        if (bitDone && filt_d) begin
          data_d  = shift_q;
          ready_d = 1'b1;
          seen_d  = 1'b1;
        end
`ifdef UART_RX_FRAME_ERR_EN
        if (bitDone && !filt_d) frameErr_d = 1'b1;
`endif
      end
      default: sampleCnt_d = '0;
    endcase

    // Gap counter only runs while waiting for a start bit; a frame always clears it.
    gapCnt_d = gapCnt_q;
    if (state_q != IDLE)                    gapCnt_d = '0;
    else if (tick && (gapCnt_q != GAP_SAT)) gapCnt_d = gapCnt_q + 1'b1;

    eop_d = seen_q && (gapCnt_q != GAP_SAT) && (gapCnt_d == GAP_SAT);
    if (eop_d) seen_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sampleCnt_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      seen_q      <= 1'b0;
      eop_q       <= 1'b0;
      gapCnt_q    <= GAP_SAT;
`ifdef UART_RX_FRAME_ERR_EN
      frameErr_q  <= 1'b0;
`endif
    end else begin
      sampleCnt_q <= sampleCnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      seen_q      <= seen_d;
      eop_q       <= eop_d;
      gapCnt_q    <= gapCnt_d;
`ifdef UART_RX_FRAME_ERR_EN
      frameErr_q  <= frameErr_d;
`endif
    end
  end

  assign rxd_data_ready  = ready_q;
  assign rxd_data        = data_q;
  assign rxd_idle        = (gapCnt_q == GAP_SAT);
  assign rxd_endofpacket = eop_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign rxd_frame_err   = frameErr_q;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: serial frames at 12 Mbaud against a byte-queue reference model.
`timescale 1ns/1ps
module tb_uart_rx_framer;

  localparam realtime CLK_NS = 10.0;
  localparam realtime BIT_NS = 1.0e9 / 12.0e6;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rxd_data_ready;
  logic [7:0] rxd_data;
  logic       rxd_idle;
  logic       rxd_endofpacket;
`ifdef UART_RX_FRAME_ERR_EN
  logic       rxd_frame_err;
`endif

  uart_rx_framer dut (
    .clk             (clk),
    .reset           (reset),
    .rxd             (rxd),
    .rxd_data_ready  (rxd_data_ready),
    .rxd_data        (rxd_data),
    .rxd_idle        (rxd_idle),
`ifdef UART_RX_FRAME_ERR_EN
    .rxd_frame_err   (rxd_frame_err),
`endif
    .rxd_endofpacket (rxd_endofpacket)
  );

  always #(CLK_NS / 2) clk = ~clk;

  int         nChecks = 0;
  int         nPass = 0;
  logic [7:0] expQ[$];
  int         rdPtr = 0;
  logic [7:0] lastGood = 8'h00;

  logic [7:0] rxBytes[$];
  realtime    rxTimes[$];
  int         eopCount = 0;
  realtime    lastEopTime = 0.0;
  int         widthErr = 0;
  int         overlapErr = 0;
  logic       prevReady = 1'b0;

  // Records every byte strobe and end-of-packet pulse seen on the falling clock edge.
  always @(negedge clk) begin
    if (rxd_data_ready) begin
      rxBytes.push_back(rxd_data);
      rxTimes.push_back($realtime);
      if (prevReady) widthErr++;
      if (rxd_endofpacket) overlapErr++;
    end
    if (rxd_endofpacket) begin
      eopCount++;
      lastEopTime = $realtime;
    end
    prevReady = rxd_data_ready;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed === expected) nPass++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Serialises one 8N1 frame (LSB first) and records what the receiver should deliver.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int gapBits,
                               output logic idleMid);
    rxd = 1'b0;
    #(BIT_NS);
    idleMid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      #(BIT_NS);
      if (i == 3) idleMid = rxd_idle;
    end
    rxd = stopBit;
    #(BIT_NS);
    rxd = 1'b1;
    #(gapBits * BIT_NS);
    if (stopBit) begin
      expQ.push_back(data);
      lastGood = data;
    end
  endtask

  task automatic checkStream(input string tag);
    int got;
    int n;
    got = rxBytes.size() - rdPtr;
    checkOutput({tag, "_count"}, got, expQ.size());
    n = (got < expQ.size()) ? got : expQ.size();
    for (int k = 0; k < n; k++) checkOutput(tag, rxBytes[rdPtr + k], expQ[k]);
    rdPtr = rxBytes.size();
    expQ.delete();
  endtask

  logic [7:0] burst[17] = '{8'h01, 8'h1d, 8'h54, 8'h68, 8'hd3, 8'h7f, 8'h38, 8'hdc, 8'h34,
                            8'hdc, 8'ha0, 8'h69, 8'h2c, 8'h3a, 8'h6f, 8'h2c, 8'h83};

  initial begin
    logic    idleMid;
    realtime t0;
    int      idx;
    int      lat;
    int      e0;

    reset = 1'b1;
    rxd   = 1'b1;
    #23;
    checkOutput("resetReady", rxd_data_ready, 0);
    checkOutput("resetData", rxd_data, 8'h00);
    checkOutput("resetIdle", rxd_idle, 1);
    checkOutput("resetEop", rxd_endofpacket, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #2;

    // Single byte with latency measurement.
    checkOutput("idleBeforeFrame", rxd_idle, 1);
    idx = rxBytes.size();
    t0  = $realtime;
    applyStimulus(8'h01, 1'b1, 3, idleMid);
    checkOutput("idleDuringFrame", idleMid, 0);
    lat = (rxTimes.size() > idx) ? int'((rxTimes[idx] - t0) / CLK_NS) : -1;
    $display("[TB] first-byte latency %0d cycles", lat);
    checkOutput("latency76to85", (lat >= 76 && lat <= 85), 1);
    checkStream("singleByte");

    // Back-to-back burst.
    for (int i = 0; i < 17; i++) applyStimulus(burst[i], 1'b1, (i == 16) ? 4 : 0, idleMid);
    checkStream("burst");

    // Glitch shorter than a start bit.
    rxd = 1'b0;
    #20;
    rxd = 1'b1;
    #(12 * BIT_NS);
    checkStream("falseStart");

    // Framing error, then recovery.
    applyStimulus(8'hA5, 1'b0, 3, idleMid);
    #(2 * BIT_NS);
    checkOutput("dataHeldAfterFrameErr", rxd_data, lastGood);
    checkStream("frameErr");
    applyStimulus(8'h3C, 1'b1, 3, idleMid);
    checkStream("afterFrameErr");

    // End-of-packet detection.
    #(5 * BIT_NS);
    e0  = eopCount;
    idx = rxBytes.size();
    applyStimulus(8'h5A, 1'b1, 1, idleMid);
    checkOutput("noEopTooEarly", eopCount, e0);
    #(3 * BIT_NS);
    checkOutput("eopOnce", eopCount, e0 + 1);
    checkOutput("idleAfterGap", rxd_idle, 1);
    lat = (rxTimes.size() > idx) ? int'((lastEopTime - rxTimes[idx]) / CLK_NS) : -1;
    checkOutput("eopDelay15to18", (lat >= 15 && lat <= 18), 1);
    #(20 * BIT_NS);
    checkOutput("noSecondEop", eopCount, e0 + 1);
    checkStream("eopByte");

    // Reset in the middle of a frame (during bit 4 of 0xF0).
    rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) #(BIT_NS);
    rxd = 1'b1;
    #(BIT_NS / 2);
    reset = 1'b1;
    #1;
    checkOutput("midResetReady", rxd_data_ready, 0);
    checkOutput("midResetData", rxd_data, 8'h00);
    checkOutput("midResetIdle", rxd_idle, 1);
    checkOutput("midResetEop", rxd_endofpacket, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #(3 * BIT_NS);
    checkStream("midResetNoStrobe");
    applyStimulus(8'h02, 1'b1, 3, idleMid);
    checkStream("afterReset");

    // Random bytes with random inter-frame gaps.
    for (int i = 0; i < 24; i++)
      applyStimulus(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 2), idleMid);
    #(4 * BIT_NS);
    checkStream("random");

    checkOutput("strobeWidthOneCycle", widthErr, 0);
    checkOutput("strobeEopExclusive", overlapErr, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
